// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot pipeline (coordinate feeder and iterators).
package mandel_pkg;

  // Signed 4.23 fixed point
  localparam int unsigned FIX_W     = 27;
  localparam int unsigned FRAC_BITS = 23;

  // Iterator limits
  localparam int unsigned ITER_MAX = 1000;
  localparam int unsigned ITER_W   = $clog2(ITER_MAX + 1);

  // Default VGA frame
  localparam int unsigned H_PIXELS_DEF = 640;
  localparam int unsigned V_PIXELS_DEF = 480;

  localparam logic [FIX_W-1:0] ONE     = 27'h0800000;
  localparam logic [FIX_W-1:0] NEG_TWO = 27'h7000000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } gen_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y pixel counter (x fastest) with row-wrap and last-pixel flags.
module raster_counter #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_PIXELS = 480,
  parameter int unsigned X_W      = $clog2(H_PIXELS),
  parameter int unsigned Y_W      = $clog2(V_PIXELS)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           row_wrap,
  output logic           last_pixel
);

  localparam logic [X_W-1:0] XLast = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] YLast = Y_W'(V_PIXELS - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;

  // Flags describe the pixel currently presented
  always_comb begin
    row_wrap   = (x_q == XLast);
    last_pixel = row_wrap && (y_q == YLast);
  end

  // Next-state: clear wins over advance; the last pixel wraps back to (0,0)
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (last_pixel) begin
        x_d = '0;
        y_d = '0;
      end else if (row_wrap) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/pixel_coord_gen.sv
// Walks the frame in raster order and emits one fixed-point complex coordinate per pixel
// over a valid/ready handshake. Coordinates are built by incremental add, never multiply.
module pixel_coord_gen
  import mandel_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_PIXELS = V_PIXELS_DEF,
  parameter int unsigned FIX_W    = mandel_pkg::FIX_W,
  parameter int unsigned X_W      = $clog2(H_PIXELS),
  parameter int unsigned Y_W      = $clog2(V_PIXELS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [FIX_W-1:0] x_min,
  input  logic [FIX_W-1:0] y_max,
  input  logic [FIX_W-1:0] dx,
  input  logic [FIX_W-1:0] dy,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [FIX_W-1:0] out_c_r,
  output logic [FIX_W-1:0] out_c_i,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic             busy,
  output logic             done
);

  gen_state_e state_q, state_d;

  logic [FIX_W-1:0] x_min_q, x_min_d;
  logic [FIX_W-1:0] dx_q, dx_d;
  logic [FIX_W-1:0] dy_q, dy_d;
  logic [FIX_W-1:0] c_r_q, c_r_d;
  logic [FIX_W-1:0] c_i_q, c_i_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cnt_clear;
  logic cnt_advance;
  logic row_wrap;
  logic last_pixel;
  logic xfer;

  assign xfer = val_q && out_rdy;

  raster_counter #(
    .H_PIXELS (H_PIXELS),
    .V_PIXELS (V_PIXELS),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_raster_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .advance    (cnt_advance),
    .x          (out_x),
    .y          (out_y),
    .row_wrap   (row_wrap),
    .last_pixel (last_pixel)
  );

  // FSM next-state, coordinate accumulators and handshake flags
  always_comb begin
    state_d     = state_q;
    x_min_d     = x_min_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    c_r_d       = c_r_q;
    c_i_d       = c_i_q;
    val_d       = val_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clear   = 1'b0;
    cnt_advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          x_min_d   = x_min;
          dx_d      = dx;
          dy_d      = dy;
          c_r_d     = x_min;
          c_i_d     = y_max;
          val_d     = 1'b1;
          busy_d    = 1'b1;
          cnt_clear = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (xfer) begin
          cnt_advance = 1'b1;
          if (last_pixel) begin
            val_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else if (row_wrap) begin
            // Reload x_min exactly so rounding never accumulates across rows
            c_r_d = x_min_q;
            c_i_d = c_i_q - dy_q;
          end else begin
            c_r_d = c_r_q + dx_q;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        val_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_min_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      c_r_q   <= '0;
      c_i_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_min_q <= x_min_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      c_r_q   <= c_r_d;
      c_i_q   <= c_i_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_val = val_q;
  assign out_c_r = c_r_q;
  assign out_c_i = c_i_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Scoreboard bench for pixel_coord_gen on a 4x3 frame.
module tb_pixel_coord_gen;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned FW = 27;
  localparam int unsigned XW = $clog2(H);
  localparam int unsigned YW = $clog2(V);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] c_r;
    logic [FW-1:0] c_i;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] x_min = '0, y_max = '0, dx = '0, dy = '0;
  logic          out_val, out_rdy;
  logic [FW-1:0] out_c_r, out_c_i;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          busy, done;

  pixel_coord_gen #(
    .H_PIXELS (H),
    .V_PIXELS (V),
    .FIX_W    (FW),
    .X_W      (XW),
    .Y_W      (YW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_min   (x_min),
    .y_max   (y_max),
    .dx      (dx),
    .dy      (dy),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_c_r (out_c_r),
    .out_c_i (out_c_i),
    .out_x   (out_x),
    .out_y   (out_y),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter and ready driver
  int unsigned cyc = 0;
  logic        rand_rdy = 1'b0;
  logic        rdy_fixed = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;
  initial out_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  pix_t        exp_q[$];
  logic        mon_en = 1'b0;
  logic        have_prev = 1'b0;
  pix_t        prev_pix;
  logic        prev_val, prev_rdy;
  int unsigned xfer_cnt, done_cnt, first_xfer_cyc, last_xfer_cyc, done_cyc;

  // Independent model: coordinate by multiplication from the frame origin
  task automatic push_frame(input logic [FW-1:0] xm, input logic [FW-1:0] ym,
                            input logic [FW-1:0] sx, input logic [FW-1:0] sy);
    pix_t p;
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        p.x   = XW'(xx);
        p.y   = YW'(yy);
        p.c_r = FW'(xm + FW'(xx) * sx);
        p.c_i = FW'(ym - FW'(yy) * sy);
        exp_q.push_back(p);
      end
    end
  endtask

  // Monitor: scoreboard pops on transfers, stall stability, busy/val relation
  always @(negedge clk) begin
    pix_t cur, e;
    cur = '{x: out_x, y: out_y, c_r: out_c_r, c_i: out_c_i};
    if (mon_en) begin
      check_eq("busy_vs_val", 32'(busy), 32'(out_val));
      if (have_prev && prev_val && !prev_rdy) begin
        check_eq("stall_val", 32'(out_val), 32'd1);
        check_eq("stall_x", 32'(cur.x), 32'(prev_pix.x));
        check_eq("stall_y", 32'(cur.y), 32'(prev_pix.y));
        check_eq("stall_cr", 32'(cur.c_r), 32'(prev_pix.c_r));
        check_eq("stall_ci", 32'(cur.c_i), 32'(prev_pix.c_i));
      end
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_xfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("px_x", 32'(cur.x), 32'(e.x));
          check_eq("px_y", 32'(cur.y), 32'(e.y));
          check_eq("px_cr", 32'(cur.c_r), 32'(e.c_r));
          check_eq("px_ci", 32'(cur.c_i), 32'(e.c_i));
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_pix  = cur;
      prev_val  = out_val;
      prev_rdy  = out_rdy;
      have_prev = 1'b1;
    end else begin
      have_prev = 1'b0;
    end
  end

  int unsigned start_cyc;

  task automatic launch(input logic [FW-1:0] xm, input logic [FW-1:0] ym,
                        input logic [FW-1:0] sx, input logic [FW-1:0] sy);
    xfer_cnt = 0;
    done_cnt = 0;
    push_frame(xm, ym, sx, sy);
    @(posedge clk);
    #2;
    x_min = xm; y_max = ym; dx = sx; dy = sy;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Wait for done (bounded); optionally re-pulse start mid-frame with a bogus x_min
  task automatic wait_done(input logic inject);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (inject && i == 3) begin
        start = 1'b1;
        x_min = 27'h0123456;
        dx    = 27'h0000001;
      end
      if (inject && i == 4) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    repeat (4) @(posedge clk);
    #2;
    check_eq("xfer_count", xfer_cnt, H * V);
    check_eq("done_count", done_cnt, 32'd1);
    check_eq("done_after_last", done_cyc, last_xfer_cyc + 1);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_val", 32'(out_val), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cr", 32'(out_c_r), 32'd0);
    check_eq("rst_ci", 32'(out_c_i), 32'd0);
    check_eq("rst_x", 32'(out_x), 32'd0);
    check_eq("rst_y", 32'(out_y), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Frame 1: ready held high, back-to-back transfers
    launch(27'h7000000, 27'h0800000, 27'h0400000, 27'h0200000);
    wait_done(1'b0);
    check_eq("first_xfer_lat", first_xfer_cyc, start_cyc + 1);
    check_eq("frame_span", last_xfer_cyc, start_cyc + H * V);
    check_eq("done_lat", done_cyc, start_cyc + H * V + 1);

    // Frame 2: random ready, same sequence expected
    rand_rdy = 1'b1;
    launch(27'h7000000, 27'h0800000, 27'h0400000, 27'h0200000);
    wait_done(1'b0);
    rand_rdy = 1'b0;

    // Frame 3: start re-pulsed mid-run with other parameters is ignored
    launch(27'h7000000, 27'h0800000, 27'h0400000, 27'h0200000);
    wait_done(1'b1);

    // Reset mid-frame at pixel (2,1)
    launch(27'h7000000, 27'h0800000, 27'h0400000, 27'h0200000);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk);
        #2;
        if (out_val && out_x == XW'(2) && out_y == YW'(1)) begin
          hit = 1'b1;
          break;
        end
      end
      check_eq("reach_2_1", 32'(hit), 32'd1);
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #2;
    check_eq("mid_rst_val", 32'(out_val), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_x", 32'(out_x), 32'd0);
    check_eq("mid_rst_y", 32'(out_y), 32'd0);
    check_eq("mid_rst_cr", 32'(out_c_r), 32'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    launch(27'h7800000, 27'h0400000, 27'h0100000, 27'h0080000);
    wait_done(1'b0);

    // Wrap-around: no saturation on overflow
    launch(27'h3FFFFFF, 27'h0000000, 27'h3FFFFFF, 27'h0000001);
    check_eq("wrap_x0_cr", 32'(out_c_r), 32'h3FFFFFF);
    @(posedge clk);
    #2;
    check_eq("wrap_x1_x", 32'(out_x), 32'd1);
    check_eq("wrap_x1_cr", 32'(out_c_r), 32'h7FFFFFE);
    wait_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
